// File: rtl/chunked_adder_sub.sv
// Chunk-serial adder/subtractor: WIDTH-bit add/sub computed CHUNK bits per
// clock with a registered inter-chunk carry. Start/done handshake, flags.
module chunked_adder_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic [IW-1:0]    r_idx;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_a_ch;
    logic [CHUNK-1:0] w_b_ch;
    logic [CHUNK:0]   w_ch;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_last;
    logic             w_cin_msb;

    // Select the active chunk and add it with the registered carry.
    always_comb begin
        w_base    = 32'(r_idx) * 32'(CHUNK);
        w_a_ch    = CHUNK'(r_a >> w_base);
        w_b_ch    = CHUNK'(r_b >> w_base);
        w_ch      = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, r_c};
        w_sum_nxt = (r_sum & ~(CMASK << w_base))
                  | (WIDTH'(w_ch[CHUNK-1:0]) << w_base);
        w_last    = (r_idx == IW'(NCH - 1));
        // Carry into the MSB recovered from the MSB's sum bit.
        w_cin_msb = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_ch[CHUNK-1];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start launches a run, last chunk ends it.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (start)  w_state_nxt = S_RUN;
            S_RUN:  if (w_last) w_state_nxt = S_IDLE;
            default:            w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, per-chunk accumulation and final flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sum  <= '0;
            r_c    <= 1'b0;
            r_idx  <= '0;
            r_done <= 1'b0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a    <= a;
                        r_b    <= sub ? ~b : b;
                        r_c    <= sub ? ~carry_in : carry_in;
                        r_idx  <= '0;
                        r_sum  <= '0;
                        r_cout <= 1'b0;
                        r_ovf  <= 1'b0;
                        r_zero <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_sum <= w_sum_nxt;
                    r_c   <= w_ch[CHUNK];
                    r_idx <= r_idx + IW'(1);
                    if (w_last) begin
                        r_done <= 1'b1;
                        r_cout <= w_ch[CHUNK];
                        r_ovf  <= w_cin_msb ^ w_ch[CHUNK];
                        r_zero <= (w_sum_nxt == '0);
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = r_done;
    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule
